// File: rtl/alu_dispatch_unit_pkg.sv
// Shared widths, ALU op codes and the issue packet layout for the ALU dispatch stage.
package alu_dispatch_unit_pkg;

   localparam int XLEN     = 32;
   localparam int TAG_W    = 5;
   localparam int NUM_TAGS = 2 ** TAG_W;
   localparam int NUM_ARCH = 32;
   localparam int REG_W    = $clog2(NUM_ARCH);
   localparam int OP_W     = 5;
   localparam int NUM_WB   = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 5'd0,
      OP_SUB  = 5'd1,
      OP_AND  = 5'd2,
      OP_OR   = 5'd3,
      OP_XOR  = 5'd4,
      OP_SLL  = 5'd5,
      OP_SRL  = 5'd6,
      OP_SRA  = 5'd7,
      OP_SLT  = 5'd8,
      OP_SLTU = 5'd9
   } alu_op_e;

   typedef struct packed {
      logic [OP_W-1:0]  op_type;
      logic [TAG_W-1:0] vdest_id;
      logic             op1_dep;
      logic [XLEN-1:0]  op1;
      logic             op2_dep;
      logic [XLEN-1:0]  op2;
   } issue_pkt_t;

   // A dependent operand carries its producer tag zero-extended in the value field.
   function automatic logic [XLEN-1:0] tag_to_operand(input logic [TAG_W-1:0] tag);
      return {{(XLEN-TAG_W){1'b0}}, tag};
   endfunction

endpackage

// File: rtl/alu_dispatch_unit_if.sv
// Decode input, reservation-station issue output and writeback snoop buses of the dispatch stage.
interface alu_dispatch_unit_if;
   import alu_dispatch_unit_pkg::*;

   logic             dec_valid;
   logic             dec_ready;
   logic [OP_W-1:0]  dec_op;
   logic [REG_W-1:0] dec_rd;
   logic [REG_W-1:0] dec_rs1;
   logic [REG_W-1:0] dec_rs2;
   logic             dec_use_imm;
   logic [XLEN-1:0]  dec_imm;

   logic             rs_full;
   logic             rs_in_en;
   logic [OP_W-1:0]  rs_op_type;
   logic [TAG_W-1:0] rs_vdest_id;
   logic             rs_op1_dep;
   logic [XLEN-1:0]  rs_op1;
   logic             rs_op2_dep;
   logic [XLEN-1:0]  rs_op2;

   logic             wb1_en;
   logic [TAG_W-1:0] wb1_vregid;
   logic [XLEN-1:0]  wb1_val;
   logic             wb2_en;
   logic [TAG_W-1:0] wb2_vregid;
   logic [XLEN-1:0]  wb2_val;
   logic             wb3_en;
   logic [TAG_W-1:0] wb3_vregid;
   logic [XLEN-1:0]  wb3_val;

   logic             idle;

   modport master (
      output dec_valid, dec_op, dec_rd, dec_rs1, dec_rs2, dec_use_imm, dec_imm, rs_full,
      output wb1_en, wb1_vregid, wb1_val, wb2_en, wb2_vregid, wb2_val, wb3_en, wb3_vregid, wb3_val,
      input  dec_ready, rs_in_en, rs_op_type, rs_vdest_id, rs_op1_dep, rs_op1, rs_op2_dep, rs_op2,
      input  idle
   );

   modport slave (
      input  dec_valid, dec_op, dec_rd, dec_rs1, dec_rs2, dec_use_imm, dec_imm, rs_full,
      input  wb1_en, wb1_vregid, wb1_val, wb2_en, wb2_vregid, wb2_val, wb3_en, wb3_vregid, wb3_val,
      output dec_ready, rs_in_en, rs_op_type, rs_vdest_id, rs_op1_dep, rs_op1, rs_op2_dep, rs_op2,
      output idle
   );

endinterface

// File: rtl/alu_dispatch_unit_tag_free_list.sv
// Bitmap of free vreg tags: hands out the lowest free tag and takes back up to three per cycle.
module alu_dispatch_unit_tag_free_list
   import alu_dispatch_unit_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           alloc_en,
   input  logic [NUM_WB-1:0]              rel_en,
   input  logic [NUM_WB-1:0][TAG_W-1:0]   rel_id,
   output logic [TAG_W-1:0]               alloc_id,
   output logic                           any_free,
   output logic                           all_free
);

   logic [NUM_TAGS-1:0] free_q;
   logic [NUM_TAGS-1:0] free_d;

   assign any_free = |free_q;
   assign all_free = &free_q;

   // Lowest-index free tag; only the registered bitmap counts, so a tag released this cycle waits.
   always_comb begin
      alloc_id = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (free_q[i]) begin
            alloc_id = TAG_W'(i);
         end
      end
   end

   // Releases set their bits first, then a same-edge allocation clears its bit.
   always_comb begin
      free_d = free_q;
      for (int k = 0; k < NUM_WB; k++) begin
         if (rel_en[k]) begin
            free_d[rel_id[k]] = 1'b1;
         end
      end
      if (alloc_en) begin
         free_d[alloc_id] = 1'b0;
      end
   end

   // Bitmap register; reset frees every tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         free_q <= '1;
      end else begin
         free_q <= free_d;
      end
   end

endmodule

// File: rtl/alu_dispatch_unit.sv
// Rename/dispatch stage: reads sources, allocates a destination tag and registers an issue packet.
module alu_dispatch_unit
   import alu_dispatch_unit_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   alu_dispatch_unit_if.slave bus
);

   logic [XLEN-1:0]               regfile [NUM_ARCH];
   logic [TAG_W-1:0]              tag_map [NUM_ARCH];
   logic [NUM_ARCH-1:0]           busy;

   logic [NUM_WB-1:0]             wb_en;
   logic [NUM_WB-1:0][TAG_W-1:0]  wb_id;
   logic [NUM_WB-1:0][XLEN-1:0]   wb_val;

   logic                          dec_ready;
   logic                          accept;
   logic                          any_free;
   logic                          all_free;
   logic [TAG_W-1:0]              alloc_id;

   logic [REG_W-1:0]              src_idx [2];
   logic                          src_dep [2];
   logic [XLEN-1:0]               src_val [2];

   issue_pkt_t                    issue_d;
   issue_pkt_t                    issue_q;
   logic                          in_en_q;

   assign wb_en  = {bus.wb3_en, bus.wb2_en, bus.wb1_en};
   assign wb_id  = {bus.wb3_vregid, bus.wb2_vregid, bus.wb1_vregid};
   assign wb_val = {bus.wb3_val, bus.wb2_val, bus.wb1_val};

   assign dec_ready     = !rst && !bus.rs_full && any_free;
   assign accept        = bus.dec_valid && dec_ready;
   assign bus.dec_ready = dec_ready;
   assign bus.idle      = all_free;

   assign src_idx[0] = bus.dec_rs1;
   assign src_idx[1] = bus.dec_rs2;

   alu_dispatch_unit_tag_free_list u_free_list (
      .clk      (clk),
      .rst      (rst),
      .alloc_en (accept),
      .rel_en   (wb_en),
      .rel_id   (wb_id),
      .alloc_id (alloc_id),
      .any_free (any_free),
      .all_free (all_free)
   );

   // Source lookup against pre-update rename state, with a same-cycle writeback bypass where the lowest bus wins.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         src_dep[s] = 1'b0;
         src_val[s] = '0;
         if (src_idx[s] != '0) begin
            if (!busy[src_idx[s]]) begin
               src_val[s] = regfile[src_idx[s]];
            end else begin
               src_dep[s] = 1'b1;
               src_val[s] = tag_to_operand(tag_map[src_idx[s]]);
               for (int k = NUM_WB - 1; k >= 0; k--) begin
                  if (wb_en[k] && (wb_id[k] == tag_map[src_idx[s]])) begin
                     src_dep[s] = 1'b0;
                     src_val[s] = wb_val[k];
                  end
               end
            end
         end
      end
   end

   // Assemble the packet that will be registered toward the reservation station.
   always_comb begin
      issue_d          = '0;
      issue_d.op_type  = bus.dec_op;
      issue_d.vdest_id = alloc_id;
      issue_d.op1_dep  = src_dep[0];
      issue_d.op1      = src_val[0];
      if (bus.dec_use_imm) begin
         issue_d.op2_dep = 1'b0;
         issue_d.op2     = bus.dec_imm;
      end else begin
         issue_d.op2_dep = src_dep[1];
         issue_d.op2     = src_val[1];
      end
   end

   // Issue register: the strobe follows acceptance each edge, the packet holds until the next accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_en_q <= 1'b0;
         issue_q <= '0;
      end else begin
         in_en_q <= accept;
         if (accept) begin
            issue_q <= issue_d;
         end
      end
   end

   // Retire writebacks into the regfile, then let a same-edge rename of rd override the busy clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
         for (int r = 0; r < NUM_ARCH; r++) begin
            regfile[r] <= '0;
            tag_map[r] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_WB; k++) begin
            if (wb_en[k]) begin
               for (int r = 1; r < NUM_ARCH; r++) begin
                  if (busy[r] && (tag_map[r] == wb_id[k])) begin
                     regfile[r] <= wb_val[k];
                     busy[r]    <= 1'b0;
                  end
               end
            end
         end
         if (accept && (bus.dec_rd != '0)) begin
            busy[bus.dec_rd]    <= 1'b1;
            tag_map[bus.dec_rd] <= alloc_id;
         end
      end
   end

   assign bus.rs_in_en    = in_en_q;
   assign bus.rs_op_type  = issue_q.op_type;
   assign bus.rs_vdest_id = issue_q.vdest_id;
   assign bus.rs_op1_dep  = issue_q.op1_dep;
   assign bus.rs_op1      = issue_q.op1;
   assign bus.rs_op2_dep  = issue_q.op2_dep;
   assign bus.rs_op2      = issue_q.op2;

endmodule

// File: tb/tb_alu_dispatch_unit.sv
// Directed bench for the ALU dispatch stage: rename, bypass, retire, tag exhaustion and stalls.
module tb_alu_dispatch_unit;
   import alu_dispatch_unit_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   alu_dispatch_unit_if bus ();

   alu_dispatch_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      bus.dec_valid   = 1'b0;
      bus.dec_op      = '0;
      bus.dec_rd      = '0;
      bus.dec_rs1     = '0;
      bus.dec_rs2     = '0;
      bus.dec_use_imm = 1'b0;
      bus.dec_imm     = '0;
      bus.rs_full     = 1'b0;
      bus.wb1_en      = 1'b0;
      bus.wb1_vregid  = '0;
      bus.wb1_val     = '0;
      bus.wb2_en      = 1'b0;
      bus.wb2_vregid  = '0;
      bus.wb2_val     = '0;
      bus.wb3_en      = 1'b0;
      bus.wb3_vregid  = '0;
      bus.wb3_val     = '0;
   endtask

   task automatic drive_dec(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic use_imm, input logic [31:0] imm);
      bus.dec_valid   = 1'b1;
      bus.dec_op      = op;
      bus.dec_rd      = rd;
      bus.dec_rs1     = rs1;
      bus.dec_rs2     = rs2;
      bus.dec_use_imm = use_imm;
      bus.dec_imm     = imm;
   endtask

   task automatic do_reset;
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (bus.rs_in_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_en got %0d want 0", bus.rs_in_en); end
      checks++; if (bus.rs_vdest_id !== 5'd0) begin errors++; $display("[TB] FAIL reset_vdest got %0d want 0", bus.rs_vdest_id); end
      checks++; if (bus.rs_op1 !== 32'd0) begin errors++; $display("[TB] FAIL reset_op1 got %0h want 0", bus.rs_op1); end
      checks++; if (bus.rs_op2 !== 32'd0) begin errors++; $display("[TB] FAIL reset_op2 got %0h want 0", bus.rs_op2); end
      checks++; if (bus.idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle got %0d want 1", bus.idle); end
      checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_in_rst got %0d want 0", bus.dec_ready); end
      rst = 1'b0;
      #1;
      checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_after got %0d want 1", bus.dec_ready); end
   endtask

   task automatic test_basic_issue;
      drive_dec(OP_ADD, 5'd1, 5'd0, 5'd0, 1'b1, 32'd5);
      tick();
      bus.dec_valid = 1'b0;
      checks++; if (bus.rs_in_en !== 1'b1) begin errors++; $display("[TB] FAIL basic_in_en got %0d want 1", bus.rs_in_en); end
      checks++; if (bus.rs_op_type !== 5'(OP_ADD)) begin errors++; $display("[TB] FAIL basic_op got %0d want %0d", bus.rs_op_type, OP_ADD); end
      checks++; if (bus.rs_vdest_id !== 5'd0) begin errors++; $display("[TB] FAIL basic_vdest got %0d want 0", bus.rs_vdest_id); end
      checks++; if ({bus.rs_op1_dep, bus.rs_op1} !== {1'b0, 32'd0}) begin errors++; $display("[TB] FAIL basic_op1 got dep %0d val %0h want dep 0 val 0", bus.rs_op1_dep, bus.rs_op1); end
      checks++; if ({bus.rs_op2_dep, bus.rs_op2} !== {1'b0, 32'd5}) begin errors++; $display("[TB] FAIL basic_op2 got dep %0d val %0h want dep 0 val 5", bus.rs_op2_dep, bus.rs_op2); end
      checks++; if (bus.idle !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle got %0d want 0", bus.idle); end
      tick();
      checks++; if (bus.rs_in_en !== 1'b0) begin errors++; $display("[TB] FAIL basic_in_en_drop got %0d want 0", bus.rs_in_en); end
   endtask

   // Continues from test_basic_issue: x1 is renamed to tag 0.
   task automatic test_dependency;
      drive_dec(OP_SUB, 5'd2, 5'd1, 5'd1, 1'b0, 32'd0);
      tick();
      bus.dec_valid = 1'b0;
      checks++; if (bus.rs_vdest_id !== 5'd1) begin errors++; $display("[TB] FAIL dep_vdest got %0d want 1", bus.rs_vdest_id); end
      checks++; if ({bus.rs_op1_dep, bus.rs_op1} !== {1'b1, 32'd0}) begin errors++; $display("[TB] FAIL dep_op1 got dep %0d val %0h want dep 1 val 0", bus.rs_op1_dep, bus.rs_op1); end
      checks++; if ({bus.rs_op2_dep, bus.rs_op2} !== {1'b1, 32'd0}) begin errors++; $display("[TB] FAIL dep_op2 got dep %0d val %0h want dep 1 val 0", bus.rs_op2_dep, bus.rs_op2); end
      bus.wb1_en = 1'b1; bus.wb1_vregid = 5'd0; bus.wb1_val = 32'd7;
      tick();
      bus.wb1_en = 1'b0;
      drive_dec(OP_ADD, 5'd4, 5'd1, 5'd0, 1'b0, 32'd0);
      tick();
      bus.dec_valid = 1'b0;
      checks++; if ({bus.rs_op1_dep, bus.rs_op1} !== {1'b0, 32'd7}) begin errors++; $display("[TB] FAIL retire_op1 got dep %0d val %0h want dep 0 val 7", bus.rs_op1_dep, bus.rs_op1); end
      checks++; if (bus.rs_vdest_id !== 5'd0) begin errors++; $display("[TB] FAIL retire_tag_reuse got %0d want 0", bus.rs_vdest_id); end
      bus.wb1_en = 1'b1; bus.wb1_vregid = 5'd0; bus.wb1_val = 32'd1;
      bus.wb2_en = 1'b1; bus.wb2_vregid = 5'd1; bus.wb2_val = 32'd2;
      tick();
      clear_inputs();
      checks++; if (bus.idle !== 1'b1) begin errors++; $display("[TB] FAIL retire_idle got %0d want 1", bus.idle); end
   endtask

   task automatic test_bypass;
      do_reset();
      drive_dec(OP_ADD, 5'd1, 5'd0, 5'd0, 1'b1, 32'd1);
      tick();
      drive_dec(OP_ADD, 5'd3, 5'd1, 5'd0, 1'b0, 32'd0);
      bus.wb2_en = 1'b1; bus.wb2_vregid = 5'd0; bus.wb2_val = 32'd9;
      tick();
      clear_inputs();
      checks++; if ({bus.rs_op1_dep, bus.rs_op1} !== {1'b0, 32'd9}) begin errors++; $display("[TB] FAIL bypass_op1 got dep %0d val %0h want dep 0 val 9", bus.rs_op1_dep, bus.rs_op1); end
      checks++; if (bus.rs_vdest_id !== 5'd1) begin errors++; $display("[TB] FAIL bypass_vdest got %0d want 1", bus.rs_vdest_id); end
      checks++; if ({bus.rs_op2_dep, bus.rs_op2} !== {1'b0, 32'd0}) begin errors++; $display("[TB] FAIL bypass_op2 got dep %0d val %0h want dep 0 val 0", bus.rs_op2_dep, bus.rs_op2); end
   endtask

   task automatic test_stale_tag;
      do_reset();
      drive_dec(OP_ADD, 5'd1, 5'd0, 5'd0, 1'b1, 32'd1);
      tick();
      drive_dec(OP_ADD, 5'd1, 5'd0, 5'd0, 1'b1, 32'd2);
      tick();
      bus.dec_valid = 1'b0;
      bus.wb1_en = 1'b1; bus.wb1_vregid = 5'd0; bus.wb1_val = 32'd3;
      tick();
      bus.wb1_en = 1'b0;
      drive_dec(OP_ADD, 5'd5, 5'd1, 5'd0, 1'b0, 32'd0);
      tick();
      clear_inputs();
      checks++; if ({bus.rs_op1_dep, bus.rs_op1} !== {1'b1, 32'd1}) begin errors++; $display("[TB] FAIL stale_op1 got dep %0d val %0h want dep 1 val 1", bus.rs_op1_dep, bus.rs_op1); end
      checks++; if (bus.rs_vdest_id !== 5'd0) begin errors++; $display("[TB] FAIL stale_vdest got %0d want 0", bus.rs_vdest_id); end
   endtask

   task automatic test_exhaust;
      logic [4:0] rd;
      do_reset();
      for (int i = 0; i < 32; i++) begin
         rd = 5'((i % 31) + 1);
         drive_dec(OP_OR, rd, 5'd0, 5'd0, 1'b1, 32'(i));
         tick();
         checks++; if ({bus.rs_in_en, bus.rs_vdest_id} !== {1'b1, 5'(i)}) begin errors++; $display("[TB] FAIL exhaust_issue_%0d got en %0d tag %0d want en 1 tag %0d", i, bus.rs_in_en, bus.rs_vdest_id, i); end
      end
      checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("[TB] FAIL exhaust_ready got %0d want 0", bus.dec_ready); end
      tick();
      checks++; if (bus.rs_in_en !== 1'b0) begin errors++; $display("[TB] FAIL exhaust_no_issue got %0d want 0", bus.rs_in_en); end
      bus.wb3_en = 1'b1; bus.wb3_vregid = 5'd17; bus.wb3_val = 32'd0;
      #1;
      checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("[TB] FAIL exhaust_wb_not_free got %0d want 0", bus.dec_ready); end
      tick();
      bus.wb3_en = 1'b0;
      #1;
      checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("[TB] FAIL exhaust_ready_again got %0d want 1", bus.dec_ready); end
      tick();
      clear_inputs();
      checks++; if ({bus.rs_in_en, bus.rs_vdest_id} !== {1'b1, 5'd17}) begin errors++; $display("[TB] FAIL exhaust_reuse got en %0d tag %0d want en 1 tag 17", bus.rs_in_en, bus.rs_vdest_id); end
   endtask

   task automatic test_rs_full;
      do_reset();
      bus.rs_full = 1'b1;
      drive_dec(OP_XOR, 5'd0, 5'd0, 5'd0, 1'b1, 32'd6);
      #1;
      checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready got %0d want 0", bus.dec_ready); end
      tick();
      checks++; if (bus.rs_in_en !== 1'b0) begin errors++; $display("[TB] FAIL full_in_en got %0d want 0", bus.rs_in_en); end
      checks++; if (bus.idle !== 1'b1) begin errors++; $display("[TB] FAIL full_idle got %0d want 1", bus.idle); end
      bus.rs_full = 1'b0;
      tick();
      clear_inputs();
      checks++; if ({bus.rs_in_en, bus.rs_vdest_id} !== {1'b1, 5'd0}) begin errors++; $display("[TB] FAIL full_release got en %0d tag %0d want en 1 tag 0", bus.rs_in_en, bus.rs_vdest_id); end
      checks++; if (bus.rs_op_type !== 5'(OP_XOR)) begin errors++; $display("[TB] FAIL full_op got %0d want %0d", bus.rs_op_type, OP_XOR); end
   endtask

   task automatic test_reset_mid;
      do_reset();
      drive_dec(OP_ADD, 5'd6, 5'd0, 5'd0, 1'b1, 32'd4);
      tick();
      checks++; if (bus.rs_in_en !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_en got %0d want 1", bus.rs_in_en); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_inputs();
      checks++; if (bus.rs_in_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_in_en_cleared got %0d want 0", bus.rs_in_en); end
      checks++; if (bus.idle !== 1'b1) begin errors++; $display("[TB] FAIL mid_idle got %0d want 1", bus.idle); end
      drive_dec(OP_ADD, 5'd7, 5'd6, 5'd0, 1'b0, 32'd0);
      tick();
      clear_inputs();
      checks++; if ({bus.rs_op1_dep, bus.rs_op1, bus.rs_vdest_id} !== {1'b0, 32'd0, 5'd0}) begin errors++; $display("[TB] FAIL mid_after got dep %0d val %0h tag %0d want dep 0 val 0 tag 0", bus.rs_op1_dep, bus.rs_op1, bus.rs_vdest_id); end
   endtask

   // Run every scenario in order, then report.
   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      clear_inputs();
      test_reset();
      test_basic_issue();
      test_dependency();
      test_bypass();
      test_stale_tag();
      test_exhaust();
      test_rs_full();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
